// File: rtl/pattern_sequencer_if.sv
// rtl/pattern_sequencer_if.sv - control and status bundle for the serial pattern sequencer
interface pattern_sequencer_if #(
  parameter int WIDTH = 16,
  parameter int LEN_W = $clog2(WIDTH + 1)
);
  logic [WIDTH-1:0] pattern_in;
  logic [LEN_W-1:0] length;
  logic             load_flag;
  logic             enable;
  logic             dir;
  logic             one_shot;
  logic             o;
  logic             busy;
  logic             done;
  logic [LEN_W-1:0] bit_index;

  // Controller side: drives the pattern and controls, observes the stream and status
  modport master (
    output pattern_in, length, load_flag, enable, dir, one_shot,
    input  o, busy, done, bit_index
  );

  // Sequencer side
  modport slave (
    input  pattern_in, length, load_flag, enable, dir, one_shot,
    output o, busy, done, bit_index
  );
endinterface

// File: rtl/pattern_sequencer.sv
// rtl/pattern_sequencer.sv - loadable windowed circular shift-register pattern generator
module pattern_sequencer #(
  parameter int WIDTH = 16,
  parameter int LEN_W = $clog2(WIDTH + 1)
) (
  input  logic              clock,
  input  logic              reset_n,
  pattern_sequencer_if.slave bus
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             o_q, o_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [LEN_W-1:0] len_clamped;
  logic [LEN_W-1:0] last_idx;
  logic [IDX_W-1:0] last_bit;
  logic [WIDTH-1:0] win_mask;
  logic [WIDTH-1:0] rot_left;
  logic [WIDTH-1:0] rot_right;
  logic             end_of_pass;

  // Datapath helpers: clamped load length and the two window rotations of the
  // current register; bits above the window pass through untouched
  always_comb begin
    len_clamped = bus.length;
    if (bus.length == '0 || bus.length > FULL_LEN) begin
      len_clamped = FULL_LEN;
    end

    last_idx    = len_q - LEN_W'(1);
    last_bit    = last_idx[IDX_W-1:0];
    end_of_pass = (cnt_q == last_idx);

    // len_q == WIDTH wraps the shift to zero, so the subtraction yields all ones
    win_mask = (WIDTH'(1) << len_q) - WIDTH'(1);

    rot_left = (shreg_q & ~win_mask)
             | ({shreg_q[WIDTH-2:0], shreg_q[WIDTH-1]} & win_mask);
    rot_left[0] = shreg_q[last_bit];

    rot_right = (shreg_q & ~win_mask)
              | ({shreg_q[0], shreg_q[WIDTH-1:1]} & win_mask);
    rot_right[last_bit] = shreg_q[0];
  end

  // Next-state logic: load beats enable; emit one bit per enabled RUN cycle
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    o_d     = o_q;

    if (bus.load_flag) begin
      shreg_d = bus.pattern_in;
      len_d   = len_clamped;
      cnt_d   = '0;
      state_d = RUN;
      o_d     = 1'b0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (bus.enable) begin
            if (bus.dir) begin
              o_d     = shreg_q[0];
              shreg_d = rot_right;
            end else begin
              o_d     = shreg_q[last_bit];
              shreg_d = rot_left;
            end
            if (end_of_pass) begin
              cnt_d = '0;
              if (bus.one_shot) begin
                state_d = DONE;
              end
            end else begin
              cnt_d = cnt_q + LEN_W'(1);
            end
          end
        end
        default: begin
          o_d = 1'b0;
        end
      endcase
    end

    // Status is registered from the next state so it lines up with o
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // State register; reset wins over load
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      len_q   <= FULL_LEN;
      cnt_q   <= '0;
      o_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      o_q     <= o_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.o         = o_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.bit_index = cnt_q;

endmodule

// File: tb/tb_pattern_sequencer.sv
// tb/tb_pattern_sequencer.sv - self-checking bench for pattern_sequencer
module tb_pattern_sequencer;

  localparam int WIDTH = 16;
  localparam int LEN_W = 5;

  logic clock = 1'b0;
  logic reset_n;

  always #5 clock = ~clock;

  pattern_sequencer_if #(.WIDTH(WIDTH), .LEN_W(LEN_W)) bus ();

  pattern_sequencer #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic        rst_n;
    logic        load;
    logic [15:0] pat;
    logic [4:0]  len;
    logic        en;
    logic        dir;
    logic        os;
    logic        o;
    logic        busy;
    logic        done;
    logic [4:0]  idx;
  } vec_t;

  vec_t tbl[$];

  // behavioural reference: window held as a bit list, index 0 = pattern bit 0
  bit win[$];
  int m_cnt;
  bit m_run, m_done, m_o;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic drive(input logic r, input logic ld, input logic [15:0] pat,
                       input logic [4:0] len, input logic en, input logic d,
                       input logic os);
    reset_n        = r;
    bus.load_flag  = ld;
    bus.pattern_in = pat;
    bus.length     = len;
    bus.enable     = en;
    bus.dir        = d;
    bus.one_shot   = os;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_out(input string name, input logic o, input logic busy,
                            input logic done, input int idx);
    check({name, ".o"},    int'(bus.o),         int'(o));
    check({name, ".busy"}, int'(bus.busy),      int'(busy));
    check({name, ".done"}, int'(bus.done),      int'(done));
    check({name, ".idx"},  int'(bus.bit_index), idx);
  endtask

  // MSB-first stream of an L-bit window: k-th emitted bit is pattern bit L-1-(k mod L)
  task automatic expect_stream(input string name, input logic [15:0] pat, input int L,
                               input int k0, input int n);
    for (int k = k0; k < k0 + n; k++) begin
      step();
      expect_out($sformatf("%s[%0d]", name, k), pat[L - 1 - (k % L)], 1'b1, 1'b0,
                 (k + 1) % L);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic ld, input logic [15:0] pat,
                              input logic [4:0] len, input logic en, input logic d,
                              input logic os, input logic o, input logic busy,
                              input logic done, input logic [4:0] idx);
    vec_t v;
    v.rst_n = r; v.load = ld; v.pat = pat; v.len = len; v.en = en; v.dir = d;
    v.os = os; v.o = o; v.busy = busy; v.done = done; v.idx = idx;
    return v;
  endfunction

  task automatic model_step(input logic r, input logic ld, input logic [15:0] pat,
                            input logic [4:0] len, input logic en, input logic d,
                            input logic os);
    int L;
    if (!r) begin
      m_run = 0; m_done = 0; m_o = 0; m_cnt = 0;
      win.delete();
      repeat (WIDTH) win.push_back(1'b0);
    end else if (ld) begin
      L = (len == 0 || int'(len) > WIDTH) ? WIDTH : int'(len);
      win.delete();
      for (int i = 0; i < L; i++) win.push_back(pat[i]);
      m_cnt = 0; m_run = 1; m_done = 0; m_o = 0;
    end else if (m_run) begin
      if (en) begin
        if (!d) begin
          m_o = win.pop_back();
          win.push_front(m_o);
        end else begin
          m_o = win.pop_front();
          win.push_back(m_o);
        end
        m_cnt++;
        if (m_cnt == win.size()) begin
          m_cnt = 0;
          if (os) begin
            m_run = 0;
            m_done = 1;
          end
        end
      end
    end else begin
      m_o = 0;
    end
  endtask

  initial begin
    logic        r, ld, en, d, os;
    logic [15:0] pat;
    logic [4:0]  len;

    // reset, one-shot short window, LSB-first, palindrome, reset-over-load
    tbl.push_back(mk(0,0,16'h0000,0,0,0,0, 0,0,0,0));
    tbl.push_back(mk(0,0,16'h0000,0,0,0,0, 0,0,0,0));
    tbl.push_back(mk(1,1,16'h0009,4,1,0,1, 0,1,0,0));
    tbl.push_back(mk(1,0,16'h0009,4,1,0,1, 1,1,0,1));
    tbl.push_back(mk(1,0,16'h0009,4,1,0,1, 0,1,0,2));
    tbl.push_back(mk(1,0,16'h0009,4,1,0,1, 0,1,0,3));
    tbl.push_back(mk(1,0,16'h0009,4,1,0,1, 1,0,1,0));
    tbl.push_back(mk(1,0,16'h0009,4,1,0,1, 0,0,1,0));
    for (int i = 0; i < 10; i++) tbl.push_back(mk(1,0,16'h0009,4,1,0,1, 0,0,1,0));
    tbl.push_back(mk(1,1,16'h0006,4,1,1,1, 0,1,0,0));
    tbl.push_back(mk(1,0,16'h0006,4,1,1,1, 0,1,0,1));
    tbl.push_back(mk(1,0,16'h0006,4,1,1,1, 1,1,0,2));
    tbl.push_back(mk(1,0,16'h0006,4,1,1,1, 1,1,0,3));
    tbl.push_back(mk(1,0,16'h0006,4,1,1,1, 0,0,1,0));
    tbl.push_back(mk(1,1,16'h0006,4,1,0,1, 0,1,0,0));
    tbl.push_back(mk(1,0,16'h0006,4,1,0,1, 0,1,0,1));
    tbl.push_back(mk(1,0,16'h0006,4,1,0,1, 1,1,0,2));
    tbl.push_back(mk(1,0,16'h0006,4,1,0,1, 1,1,0,3));
    tbl.push_back(mk(1,0,16'h0006,4,1,0,1, 0,0,1,0));
    tbl.push_back(mk(1,1,16'h0003,4,1,1,1, 0,1,0,0));
    tbl.push_back(mk(1,0,16'h0003,4,1,1,1, 1,1,0,1));
    tbl.push_back(mk(1,0,16'h0003,4,1,1,1, 1,1,0,2));
    tbl.push_back(mk(1,0,16'h0003,4,1,1,1, 0,1,0,3));
    tbl.push_back(mk(1,0,16'h0003,4,1,1,1, 0,0,1,0));
    tbl.push_back(mk(1,1,16'h0003,4,1,0,1, 0,1,0,0));
    tbl.push_back(mk(1,0,16'h0003,4,1,0,1, 0,1,0,1));
    tbl.push_back(mk(1,0,16'h0003,4,1,0,1, 0,1,0,2));
    tbl.push_back(mk(1,0,16'h0003,4,1,0,1, 1,1,0,3));
    tbl.push_back(mk(1,0,16'h0003,4,1,0,1, 1,0,1,0));
    tbl.push_back(mk(0,1,16'hFFFF,0,1,0,0, 0,0,0,0));
    tbl.push_back(mk(1,0,16'hFFFF,0,1,0,0, 0,0,0,0));
    tbl.push_back(mk(1,0,16'hFFFF,0,1,1,0, 0,0,0,0));

    drive(0, 0, 16'h0, 5'd0, 0, 0, 0);
    foreach (tbl[i]) begin
      drive(tbl[i].rst_n, tbl[i].load, tbl[i].pat, tbl[i].len, tbl[i].en,
            tbl[i].dir, tbl[i].os);
      step();
      expect_out($sformatf("tbl%0d", i), tbl[i].o, tbl[i].busy, tbl[i].done,
                 int'(tbl[i].idx));
    end

    // repeat mode MSB-first, two full passes, index wraps 15 -> 0
    drive(0, 0, 16'h0, 5'd0, 0, 0, 0);
    step(); step();
    drive(1, 1, 16'hA5F0, 5'd0, 1, 0, 0);
    step();
    expect_out("rep_load", 1'b0, 1'b1, 1'b0, 0);
    bus.load_flag = 1'b0;
    expect_stream("rep", 16'hA5F0, 16, 0, 32);

    // length above WIDTH clamps to WIDTH
    drive(1, 1, 16'hA5F0, 5'd20, 1, 0, 0);
    step();
    expect_out("clamp_load", 1'b0, 1'b1, 1'b0, 0);
    bus.load_flag = 1'b0;
    expect_stream("clamp", 16'hA5F0, 16, 0, 16);

    // 3-bit window: upper ones never appear on o
    drive(1, 1, 16'hFFF8, 5'd3, 1, 0, 0);
    step();
    bus.load_flag = 1'b0;
    expect_stream("win3", 16'hFFF8, 3, 0, 9);

    // enable stall after the 5th bit
    drive(1, 1, 16'hF00F, 5'd0, 1, 0, 0);
    step();
    bus.load_flag = 1'b0;
    expect_stream("stall", 16'hF00F, 16, 0, 5);
    bus.enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      expect_out($sformatf("stall_hold%0d", i), 1'b0, 1'b1, 1'b0, 5);
    end
    bus.enable = 1'b1;
    expect_stream("stall", 16'hF00F, 16, 5, 16);

    // reload mid one-shot restarts the pass without raising done
    drive(1, 1, 16'h0009, 5'd4, 1, 0, 1);
    step();
    bus.load_flag = 1'b0;
    expect_stream("restart_a", 16'h0009, 4, 0, 2);
    bus.load_flag = 1'b1;
    step();
    expect_out("restart_load", 1'b0, 1'b1, 1'b0, 0);
    bus.load_flag = 1'b0;
    expect_stream("restart_b", 16'h0009, 4, 0, 3);
    step();
    expect_out("restart_end", 1'b1, 1'b0, 1'b1, 0);

    // randomized traffic against the reference model
    drive(0, 0, 16'h0, 5'd0, 0, 0, 0);
    model_step(0, 0, 16'h0, 5'd0, 0, 0, 0);
    step();
    for (int c = 0; c < 2000; c++) begin
      r   = ($urandom_range(0, 99) != 0);
      ld  = ($urandom_range(0, 19) == 0);
      pat = 16'($urandom);
      len = 5'($urandom_range(0, 31));
      en  = ($urandom_range(0, 3) != 0);
      d   = 1'($urandom);
      os  = 1'($urandom);
      drive(r, ld, pat, len, en, d, os);
      model_step(r, ld, pat, len, en, d, os);
      step();
      expect_out($sformatf("rnd%0d", c), m_o, m_run, m_done, m_cnt);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pattern_sequencer.md
Name: pattern_sequencer

Overview:
Parametrised serial pattern generator, the next generation of the 16-bit loadable circular shift-register pulse generator. It loads a WIDTH-bit pattern and emits it one bit per enabled clock. The following are runtime-selectable:
- active pattern length
- shift direction (MSB-first or LSB-first)
- repeat mode or one-shot mode

Status outputs (busy, done, bit_index) let a controlling FSM sequence patterns back-to-back.

Parameters:
WIDTH, 16, pattern register width in bits (>=2)
LEN_W, $clog2(WIDTH+1), width of the length and bit_index fields

Ports:
clock  input  1  system clock; all state updates on the rising edge
reset_n  input  1  synchronous, active-low reset
pattern_in  input  WIDTH  pattern captured on load
length  input  LEN_W  active pattern length; 0 or >WIDTH means WIDTH
load_flag  input  1  load pattern_in/length and start a run
enable  input  1  advance one bit this cycle
dir  input  1  0 = MSB-first (rotate left), 1 = LSB-first (rotate right)
one_shot  input  1  1 = stop after one full pattern, 0 = repeat forever
o  output  1  registered serial output bit
busy  output  1  high while in RUN
done  output  1  high after a one-shot run completes; held until next load or reset
bit_index  output  LEN_W  position within the current pass, 0..len_q-1

Behaviour:
- Reset (reset_n=0 at a rising edge) overrides all other inputs, including load_flag. It sets shreg=0, len_q=WIDTH, cnt=0, state=IDLE, o=0, busy=0, done=0.
- The FSM has three states: IDLE, RUN, DONE. busy = (state==RUN). done = (state==DONE).
- Load (load_flag=1, any state):
  - shreg<=pattern_in; len_q<=clamped length; cnt<=0; state<=RUN; o<=0.
  - load has priority over enable; no bit is emitted on a load edge.
  - one_shot and dir are sampled every cycle and are not latched at load.
- RUN with enable=1 (active window = shreg[len_q-1:0]; bits above the window are never modified):
  - dir=0: o<=shreg[len_q-1]; window rotates left, shreg[0]<=shreg[len_q-1].
  - dir=1: o<=shreg[0]; window rotates right, shreg[len_q-1]<=shreg[0].
  - Latency: a bit reaches o one cycle after the enabling edge.
- End of pass (cnt==len_q-1 when enabled):
  - cnt<=0.
  - If one_shot=1, state<=DONE. done rises on the same edge that puts the last bit on o.
  - After a complete pass the window equals its loaded value.
- RUN with enable=0: shreg, cnt, o and state all hold.
- IDLE and DONE: enable is ignored and o<=0 (o reads 0 on the first cycle after the pass's final bit). In DONE, done stays 1 until a load or reset.
- Changing dir mid-pass takes effect on the next enabled edge; cnt continues counting.
- bit_index = cnt (the index of the next bit to emit).
- len_q=1 degenerates to emitting shreg[0] every enabled cycle; in one-shot mode it completes after one bit.

Test Plan:
1. Repeat mode, MSB-first: reset_n=0 for 2 cycles, then load 16'hA5F0 with length=0, dir=0, one_shot=0, enable=1. Required: o over 32 cycles = 1010 0101 1111 0000 repeated twice; busy=1 throughout; bit_index wraps 15->0.
2. One-shot, short length: load 16'h0009, length=4, dir=0, one_shot=1, enable=1. Required: o = 1,0,0,1; done=1 and busy=0 in the same cycle o shows the final 1; o=0 on the following cycle; done stays 1 for 10 further cycles.
3. LSB-first: load 16'h0006, length=4, dir=1, one_shot=1. Required: o = 0,1,1,0, then done=1. Reload with dir=0 gives o = 0,1,1,0 (palindrome check); repeat with 16'h0003 to get 1,1,0,0 versus 0,0,1,1.
4. Enable stalls: a 16'hF00F repeat stream with enable held low for 3 cycles after the 5th bit. Required: o and bit_index frozen for 3 cycles; the stream resumes at bit 5 with no lost or duplicated bits.
5. Priority cases:
   - load_flag pulsed mid one-shot: the pass restarts from bit 0 and done stays 0.
   - reset_n=0 together with load_flag=1: all outputs go to 0, state is IDLE, and the pattern is not loaded.
6. Length clamp and window: length=20 with WIDTH=16 behaves exactly like length=16. With length=3 and pattern 16'hFFF8, o = 0,0,0 repeated, and the upper bits never reach o.
